// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset sequencer.
// Optional performance counters are enabled with CTRL_PERF_EN.
package ctrl_pkg;

  localparam int OPW   = 6;
  localparam int ALUCW = 3;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_t;

  localparam logic [OPW-1:0] OP_R    = 6'b000000;
  localparam logic [OPW-1:0] OP_LW   = 6'b100011;
  localparam logic [OPW-1:0] OP_SW   = 6'b101011;
  localparam logic [OPW-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OPW-1:0] OP_ADDI = 6'b001000;
  localparam logic [OPW-1:0] OP_J    = 6'b000010;

  localparam logic [ALUCW-1:0] ALU_FUNCT = 3'b000;
  localparam logic [ALUCW-1:0] ALU_ADD   = 3'b001;
  localparam logic [ALUCW-1:0] ALU_SUB   = 3'b010;

  typedef struct packed {
    logic             mem_req;
    logic             PcW;
    logic             IrW;
    logic             BR_En;
    logic [ALUCW-1:0] AluC;
    logic             EnW;
    logic             EnR;
    logic             Mux1;
    logic             regDest;
    logic             AluSRC;
    logic             Branch;
    logic             Jump;
    logic             instr_done;
  } ctrl_out_t;

  function automatic logic is_supported(input logic [OPW-1:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Sequencer <-> datapath/memory bundle; master is the controller side.
// Perf counter signals exist only when CTRL_PERF_EN is defined.
interface multicycle_ctrl_if;

  logic [ctrl_pkg::OPW-1:0]   Opcode;
  logic                       mem_ready;
  logic                       mem_req;
  logic                       PcW;
  logic                       IrW;
  logic                       BR_En;
  logic [ctrl_pkg::ALUCW-1:0] AluC;
  logic                       EnW;
  logic                       EnR;
  logic                       Mux1;
  logic                       regDest;
  logic                       AluSRC;
  logic                       Branch;
  logic                       Jump;
  logic                       instr_done;
  logic                       illegal;
`ifdef CTRL_PERF_EN
  logic [31:0]                cycle_cnt;
  logic [31:0]                instr_cnt;
`endif

  modport master (
`ifdef CTRL_PERF_EN
    output cycle_cnt, instr_cnt,
`endif
    input  Opcode, mem_ready,
    output mem_req, PcW, IrW, BR_En, AluC, EnW, EnR, Mux1, regDest,
           AluSRC, Branch, Jump, instr_done, illegal
  );

  modport slave (
`ifdef CTRL_PERF_EN
    input  cycle_cnt, instr_cnt,
`endif
    output Opcode, mem_ready,
    input  mem_req, PcW, IrW, BR_En, AluC, EnW, EnR, Mux1, regDest,
           AluSRC, Branch, Jump, instr_done, illegal
  );

endinterface

// File: rtl/multicycle_ctrl_out_decode.sv
// Combinational map from (state, latched opcode, mem_ready) to datapath controls.
// Independent of CTRL_PERF_EN.
module ctrl_out_decode
  import ctrl_pkg::*;
(
  input  state_t         state,
  input  logic [OPW-1:0] op_q,
  input  logic           mem_ready,
  output ctrl_out_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_req = 1'b1;
        ctrl.EnR     = 1'b1;
        ctrl.AluSRC  = 1'b1;
        ctrl.AluC    = ALU_ADD;
        ctrl.IrW     = mem_ready;
        ctrl.PcW     = mem_ready;
      end
      ST_EXEC: begin
        case (op_q)
          OP_R:                 ctrl.AluC = ALU_FUNCT;
          OP_LW, OP_SW, OP_ADDI: begin
            ctrl.AluC   = ALU_ADD;
            ctrl.AluSRC = 1'b1;
          end
          OP_BEQ: begin
            ctrl.AluC       = ALU_SUB;
            ctrl.Branch     = 1'b1;
            ctrl.instr_done = 1'b1;
          end
          OP_J: begin
            ctrl.Jump       = 1'b1;
            ctrl.PcW        = 1'b1;
            ctrl.instr_done = 1'b1;
          end
          default: ctrl = '0;
        endcase
      end
      ST_MEM: begin
        ctrl.mem_req = 1'b1;
        ctrl.EnR     = (op_q == OP_LW);
        // Store strobe only in the completing cycle, so one write per access
        ctrl.EnW        = (op_q == OP_SW) && mem_ready;
        ctrl.instr_done = (op_q == OP_SW) && mem_ready;
      end
      ST_WB: begin
        ctrl.BR_En      = 1'b1;
        ctrl.instr_done = 1'b1;
        ctrl.regDest    = (op_q == OP_R);
        ctrl.Mux1       = (op_q == OP_LW);
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer; holds state, op_q and the sticky illegal flag.
// Define CTRL_PERF_EN to add cycle_cnt/instr_cnt counters.
//
// state  | meaning
// FETCH  | read instruction, PC+4; wait for mem_ready
// DECODE | latch opcode, trap on unsupported
// EXEC   | ALU op / branch / jump
// MEM    | data load or store; wait for mem_ready
// WB     | register bank write
// TRAP   | illegal opcode, parked until reset
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master bus
);

  state_t         state, state_nxt;
  logic [OPW-1:0] op_q;
  logic           illegal_q;
  ctrl_out_t      dec, gated;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_FETCH;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_DECODE) begin
        op_q <= bus.Opcode;
        if (!is_supported(bus.Opcode)) illegal_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH:  if (bus.mem_ready) state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = is_supported(bus.Opcode) ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        case (op_q)
          OP_R, OP_ADDI: state_nxt = ST_WB;
          OP_LW, OP_SW:  state_nxt = ST_MEM;
          default:       state_nxt = ST_FETCH;
        endcase
      end
      ST_MEM:    if (bus.mem_ready) state_nxt = (op_q == OP_LW) ? ST_WB : ST_FETCH;
      ST_WB:     state_nxt = ST_FETCH;
      ST_TRAP:   state_nxt = ST_TRAP;
      default:   state_nxt = ST_FETCH;
    endcase
  end

  ctrl_out_decode u_dec (
    .state     (state),
    .op_q      (op_q),
    .mem_ready (bus.mem_ready),
    .ctrl      (dec)
  );

  // Reset forces FETCH, whose decode would request memory; mask everything while rst is high
  assign gated = rst ? '0 : dec;

  assign bus.mem_req    = gated.mem_req;
  assign bus.PcW        = gated.PcW;
  assign bus.IrW        = gated.IrW;
  assign bus.BR_En      = gated.BR_En;
  assign bus.AluC       = gated.AluC;
  assign bus.EnW        = gated.EnW;
  assign bus.EnR        = gated.EnR;
  assign bus.Mux1       = gated.Mux1;
  assign bus.regDest    = gated.regDest;
  assign bus.AluSRC     = gated.AluSRC;
  assign bus.Branch     = gated.Branch;
  assign bus.Jump       = gated.Jump;
  assign bus.instr_done = gated.instr_done;
  assign bus.illegal    = illegal_q;

`ifdef CTRL_PERF_EN
  logic [31:0] cycle_cnt_q, instr_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else if (state != ST_TRAP) begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (dec.instr_done) instr_cnt_q <= instr_cnt_q + 32'd1;
    end
  end

  assign bus.cycle_cnt = cycle_cnt_q;
  assign bus.instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle output vectors checked against hand-derived constants.
// Counter checks are compiled in when CTRL_PERF_EN is defined.
module tb_multicycle_ctrl;

  logic clk;
  logic rst;
  int   errs   = 0;
  int   checks = 0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // [15]mem_req [14]PcW [13]IrW [12]BR_En [11:9]AluC [8]EnW [7]EnR [6]Mux1
  // [5]regDest [4]AluSRC [3]Branch [2]Jump [1]instr_done [0]illegal
  logic [15:0] outv;
  assign outv = {bus.mem_req, bus.PcW, bus.IrW, bus.BR_En, bus.AluC, bus.EnW, bus.EnR,
                 bus.Mux1, bus.regDest, bus.AluSRC, bus.Branch, bus.Jump,
                 bus.instr_done, bus.illegal};

  localparam logic [15:0] V_ZERO   = 16'h0000;
  localparam logic [15:0] V_F_RDY  = 16'b1110_001_0_1_0_0_1_0_0_0_0;
  localparam logic [15:0] V_F_WAIT = 16'b1000_001_0_1_0_0_1_0_0_0_0;
  localparam logic [15:0] V_E_R    = 16'b0000_000_0_0_0_0_0_0_0_0_0;
  localparam logic [15:0] V_E_IMM  = 16'b0000_001_0_0_0_0_1_0_0_0_0;
  localparam logic [15:0] V_E_BEQ  = 16'b0000_010_0_0_0_0_0_1_0_1_0;
  localparam logic [15:0] V_E_J    = 16'b0100_000_0_0_0_0_0_0_1_1_0;
  localparam logic [15:0] V_M_LW   = 16'b1000_000_0_1_0_0_0_0_0_0_0;
  localparam logic [15:0] V_M_SW_W = 16'b1000_000_0_0_0_0_0_0_0_0_0;
  localparam logic [15:0] V_M_SW_R = 16'b1000_000_1_0_0_0_0_0_0_1_0;
  localparam logic [15:0] V_WB_R   = 16'b0001_000_0_0_0_1_0_0_0_1_0;
  localparam logic [15:0] V_WB_ADD = 16'b0001_000_0_0_0_0_0_0_0_1_0;
  localparam logic [15:0] V_WB_LW  = 16'b0001_000_0_0_1_0_0_0_0_1_0;
  localparam logic [15:0] V_TRAP   = 16'b0000_000_0_0_0_0_0_0_0_0_1;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Drive inputs for this cycle, check outputs mid-cycle, then advance past the next edge
  task automatic cyc(input string tag, input logic rdy, input logic [5:0] op,
                     input logic [15:0] expv);
    bus.mem_ready = rdy;
    bus.Opcode    = op;
    #1;
    check_eq(tag, {16'h0, outv}, {16'h0, expv});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst           = 1'b1;
    bus.mem_ready = 1'b1;
    bus.Opcode    = OP_R;
    #2;
    check_eq("reset_outputs", {16'h0, outv}, {16'h0, V_ZERO});
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // R-type with Opcode scrambled after DECODE
    cyc("r_fetch",  1'b1, OP_R,   V_F_RDY);
    cyc("r_decode", 1'b1, OP_R,   V_ZERO);
    cyc("r_exec",   1'b1, OP_BAD, V_E_R);
    cyc("r_wb",     1'b1, OP_LW,  V_WB_R);
`ifdef CTRL_PERF_EN
    #1;
    check_eq("perf_cycles", bus.cycle_cnt, 32'd4);
    check_eq("perf_instr",  bus.instr_cnt, 32'd1);
`endif

    // lw with two wait states in MEM
    cyc("lw_fetch",  1'b1, OP_LW, V_F_RDY);
    cyc("lw_decode", 1'b1, OP_LW, V_ZERO);
    cyc("lw_exec",   1'b1, OP_LW, V_E_IMM);
    cyc("lw_mem_w0", 1'b0, OP_LW, V_M_LW);
    cyc("lw_mem_w1", 1'b0, OP_LW, V_M_LW);
    cyc("lw_mem_rd", 1'b1, OP_LW, V_M_LW);
    cyc("lw_wb",     1'b1, OP_LW, V_WB_LW);

    // sw, zero wait
    cyc("sw_fetch",  1'b1, OP_SW, V_F_RDY);
    cyc("sw_decode", 1'b1, OP_SW, V_ZERO);
    cyc("sw_exec",   1'b1, OP_SW, V_E_IMM);
    cyc("sw_mem",    1'b1, OP_SW, V_M_SW_R);

    // beq then j back to back
    cyc("beq_fetch",  1'b1, OP_BEQ, V_F_RDY);
    cyc("beq_decode", 1'b1, OP_BEQ, V_ZERO);
    cyc("beq_exec",   1'b1, OP_BEQ, V_E_BEQ);
    cyc("j_fetch",    1'b1, OP_J,   V_F_RDY);
    cyc("j_decode",   1'b1, OP_J,   V_ZERO);
    cyc("j_exec",     1'b1, OP_J,   V_E_J);

    // addi with one fetch wait state
    cyc("addi_fetch_w", 1'b0, OP_ADDI, V_F_WAIT);
    cyc("addi_fetch",   1'b1, OP_ADDI, V_F_RDY);
    cyc("addi_decode",  1'b1, OP_ADDI, V_ZERO);
    cyc("addi_exec",    1'b1, OP_ADDI, V_E_IMM);
    cyc("addi_wb",      1'b1, OP_ADDI, V_WB_ADD);

    // reset in the middle of a stalled store
    cyc("swr_fetch",  1'b1, OP_SW, V_F_RDY);
    cyc("swr_decode", 1'b1, OP_SW, V_ZERO);
    cyc("swr_exec",   1'b1, OP_SW, V_E_IMM);
    cyc("swr_mem_w",  1'b0, OP_SW, V_M_SW_W);
    rst           = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    check_eq("swr_rst_outputs", {16'h0, outv}, {16'h0, V_ZERO});
    @(posedge clk); #1;
    rst = 1'b0;
    cyc("swr_post_fetch", 1'b0, OP_SW, V_F_WAIT);
    cyc("swr2_fetch",     1'b1, OP_SW, V_F_RDY);
    cyc("swr2_decode",    1'b1, OP_SW, V_ZERO);
    cyc("swr2_exec",      1'b1, OP_SW, V_E_IMM);
    cyc("swr2_mem",       1'b1, OP_SW, V_M_SW_R);

    // illegal opcode: sticky trap, no memory traffic
    cyc("bad_fetch",  1'b1, OP_BAD, V_F_RDY);
    cyc("bad_decode", 1'b1, OP_BAD, V_ZERO);
    for (int i = 0; i < 20; i++) begin
      cyc($sformatf("trap_%0d", i), logic'(i[0]), OP_R, V_TRAP);
    end
    rst = 1'b1;
    #1;
    check_eq("trap_rst_outputs", {16'h0, outv}, {16'h0, V_ZERO});
    @(posedge clk); #1;
    rst = 1'b0;
    cyc("trap_post_fetch", 1'b0, OP_R, V_F_WAIT);
    cyc("trap_post_rdy",   1'b1, OP_R, V_F_RDY);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
